// File: rtl/ihex_loader.sv
// ihex_loader
//   Parses an Intel HEX (INHX8M/INHX32) ASCII stream coming from the UART
//   receiver. It checks each record's checksum and writes the decoded 14-bit
//   PIC program words into the single-port program RAM.
//
// Ports
//   CLK_UART_i    system clock shared with the uart and the program RAM
//   rst_i         asynchronous active-high reset
//   rx_data_i     received ASCII character
//   rx_valid_i    one-cycle strobe, rx_data_i valid
//   mem_addr_o    RAM word address (held until the next write)
//   mem_data_o    RAM write data   (held until the next write)
//   mem_we_o      one-cycle RAM write strobe
//   busy_o        high while a record is being parsed
//   done_o        sticky, a valid EOF record was received
//   error_o       sticky, a format or checksum error was seen since reset
//   word_count_o  number of RAM writes issued (wraps)
module ihex_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK_UART_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [13:0]       mem_data_o,
  output logic              mem_we_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [15:0]       word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_ADDR = 3'd2,
    S_TYPE = 3'd3,
    S_DATA = 3'd4,
    S_CSUM = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_n_s;

  logic        half_r;     // high nibble of the current byte already captured
  logic [3:0]  hi_nib_r;
  logic [7:0]  fld_cnt_r;  // byte index inside the current field
  logic [7:0]  len_r;
  logic [15:0] addr_r;
  logic [7:0]  type_r;
  logic [7:0]  sum_r;
  logic [7:0]  lo_r;       // first byte of a data pair
  logic [15:0] ext_hi_r;
  logic        skip_r;     // misaligned data record: parse it but never write

  logic [4:0]  hex_s;
  logic        is_colon_s;
  logic        in_rec_s;
  logic [7:0]  byte_s;
  logic [7:0]  sum_next_s;
  logic        byte_done_s;
  logic [30:0] word_addr_s;
  logic        in_range_s;
  logic        wr_s;
  logic        err_s;
  logic        done_s;

  // ASCII hex digit to {valid, nibble}; any other character gives valid = 0
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    logic [4:0] r;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      r = {1'b1, c[3:0]};
    end else if (((c >= 8'h41) && (c <= 8'h46)) || ((c >= 8'h61) && (c <= 8'h66))) begin
      r = {1'b1, c[3:0] + 4'd9};
    end else begin
      r = 5'd0;
    end
    return r;
  endfunction

  // Character decode and write-address computation
  always_comb begin
    hex_s       = hex_nibble(rx_data_i);
    is_colon_s  = (rx_data_i == 8'h3A);
    in_rec_s    = (state_r == S_LEN) || (state_r == S_ADDR) || (state_r == S_TYPE) ||
                  (state_r == S_DATA) || (state_r == S_CSUM);
    byte_s      = {hi_nib_r, hex_s[3:0]};
    sum_next_s  = sum_r + byte_s;
    byte_done_s = rx_valid_i && in_rec_s && hex_s[4] && half_r;
    // Writes only happen with an even base address and on the odd (high)
    // byte, so ({ext_hi, AAAA} + idx) >> 1 reduces to base/2 + idx/2.
    word_addr_s = {ext_hi_r, addr_r[15:1]} + {24'd0, fld_cnt_r[7:1]};
    in_range_s  = ((word_addr_s >> ADDR_W) == 31'd0);
    wr_s        = byte_done_s && (state_r == S_DATA) && (type_r == 8'h00) &&
                  !skip_r && fld_cnt_r[0] && in_range_s;
  end

  // FSM state register
  always_ff @(posedge CLK_UART_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // FSM next state plus error/done events
  always_comb begin
    state_n_s = state_r;
    err_s     = 1'b0;
    done_s    = 1'b0;
    if (rx_valid_i) begin
      case (state_r)
        S_IDLE: begin
          if (is_colon_s) begin
            state_n_s = S_LEN;
          end else begin
            state_n_s = S_IDLE;
          end
        end
        S_DONE: begin
          state_n_s = S_DONE;
        end
        default: begin
          if (is_colon_s) begin
            // A stray ':' aborts the current record and opens a new one
            err_s     = 1'b1;
            state_n_s = S_LEN;
          end else if (!hex_s[4]) begin
            err_s     = 1'b1;
            state_n_s = S_IDLE;
          end else if (half_r) begin
            case (state_r)
              S_LEN: begin
                state_n_s = S_ADDR;
              end
              S_ADDR: begin
                if (fld_cnt_r == 8'd1) begin
                  state_n_s = S_TYPE;
                end else begin
                  state_n_s = S_ADDR;
                end
              end
              S_TYPE: begin
                if (len_r == 8'd0) begin
                  state_n_s = S_CSUM;
                end else begin
                  state_n_s = S_DATA;
                end
                if ((byte_s == 8'h00) && (len_r[0] || addr_r[0])) begin
                  err_s = 1'b1;
                end else if ((byte_s == 8'h04) && (len_r != 8'd2)) begin
                  err_s = 1'b1;
                end else begin
                  err_s = 1'b0;
                end
              end
              S_DATA: begin
                if (fld_cnt_r == (len_r - 8'd1)) begin
                  state_n_s = S_CSUM;
                end else begin
                  state_n_s = S_DATA;
                end
              end
              S_CSUM: begin
                if (sum_next_s != 8'h00) begin
                  err_s     = 1'b1;
                  state_n_s = S_IDLE;
                end else if (type_r == 8'h01) begin
                  done_s    = 1'b1;
                  state_n_s = S_DONE;
                end else begin
                  state_n_s = S_IDLE;
                end
              end
              default: begin
                state_n_s = S_IDLE;
              end
            endcase
          end else begin
            state_n_s = state_r;
          end
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // Field capture, running checksum, RAM write port and status flags
  always_ff @(posedge CLK_UART_i or posedge rst_i) begin
    if (rst_i) begin
      half_r       <= 1'b0;
      hi_nib_r     <= 4'd0;
      fld_cnt_r    <= 8'd0;
      len_r        <= 8'd0;
      addr_r       <= 16'd0;
      type_r       <= 8'd0;
      sum_r        <= 8'd0;
      lo_r         <= 8'd0;
      ext_hi_r     <= 16'd0;
      skip_r       <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= 14'd0;
      mem_we_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      word_count_o <= 16'd0;
    end else begin
      mem_we_o <= 1'b0;
      busy_o   <= (state_n_s == S_LEN) || (state_n_s == S_ADDR) || (state_n_s == S_TYPE) ||
                  (state_n_s == S_DATA) || (state_n_s == S_CSUM);
      error_o  <= error_o | err_s;
      done_o   <= done_o | done_s;
      if (rx_valid_i && is_colon_s && (state_r != S_DONE)) begin
        half_r    <= 1'b0;
        fld_cnt_r <= 8'd0;
        sum_r     <= 8'd0;
      end else if (rx_valid_i && in_rec_s && hex_s[4]) begin
        if (!half_r) begin
          hi_nib_r <= hex_s[3:0];
          half_r   <= 1'b1;
        end else begin
          half_r    <= 1'b0;
          sum_r     <= sum_next_s;
          fld_cnt_r <= (state_n_s == state_r) ? (fld_cnt_r + 8'd1) : 8'd0;
          case (state_r)
            S_LEN: len_r <= byte_s;
            S_ADDR: begin
              if (fld_cnt_r == 8'd0) begin
                addr_r[15:8] <= byte_s;
              end else begin
                addr_r[7:0] <= byte_s;
              end
            end
            S_TYPE: begin
              type_r <= byte_s;
              skip_r <= (byte_s == 8'h00) && (len_r[0] || addr_r[0]);
            end
            S_DATA: begin
              if (!fld_cnt_r[0]) begin
                lo_r <= byte_s;
              end else if ((type_r == 8'h04) && (len_r == 8'd2)) begin
                ext_hi_r <= {lo_r, byte_s};
              end else begin
                lo_r <= lo_r;
              end
            end
            default: begin
              lo_r <= lo_r;
            end
          endcase
        end
      end else begin
        half_r <= half_r;
      end
      if (wr_s) begin
        mem_we_o     <= 1'b1;
        mem_addr_o   <= word_addr_s[ADDR_W-1:0];
        mem_data_o   <= {byte_s[5:0], lo_r};
        word_count_o <= word_count_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ihex_loader.sv
// Self-checking bench for ihex_loader. Two instances (ADDR_W = 10 and 14)
// receive the same character stream. A record-level reference model,
// driven by the stimulus, queues the expected RAM writes and tracks the
// expected busy/error/done flags. A monitor compares the DUT outputs
// against the model every cycle.
module tb_ihex_loader;
  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [9:0]  a10;
  logic [13:0] a14, d10, d14;
  logic        we10, we14, busy10, busy14, done10, done14, err10, err14;
  logic [15:0] wc10, wc14;

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t  q10[$];
  wr_t  q14[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   popped10 = 0;
  int   popped14 = 0;
  // reference model: phase 0 = between records, 1 = inside a record, 2 = EOF seen
  int     phase;
  bit     half;
  int     hi;
  int     rec[$];
  longint ext;
  bit     exp_err, exp_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ihex_loader #(.ADDR_W(10)) u10 (
    .CLK_UART_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .mem_addr_o(a10), .mem_data_o(d10), .mem_we_o(we10), .busy_o(busy10),
    .done_o(done10), .error_o(err10), .word_count_o(wc10));

  ihex_loader #(.ADDR_W(14)) u14 (
    .CLK_UART_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .mem_addr_o(a14), .mem_data_o(d14), .mem_we_o(we14), .busy_o(busy14),
    .done_o(done14), .error_o(err14), .word_count_o(wc14));

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int hexval(input int c);
    if (c >= 48 && c <= 57) return c - 48;
    else if (c >= 65 && c <= 70) return c - 55;
    else if (c >= 97 && c <= 102) return c - 87;
    else return -1;
  endfunction

  function automatic int hexchar(input int n);
    if (n < 10) return 48 + n;
    else if ($urandom_range(0, 1) == 1) return 87 + n;
    else return 55 + n;
  endfunction

  task automatic model_reset();
    phase = 0; half = 0; hi = 0; rec.delete(); ext = 0;
    exp_err = 0; exp_done = 0;
    q10.delete(); q14.delete();
    popped10 = 0; popped14 = 0;
  endtask

  task automatic push_write(input longint full, input int data);
    wr_t e;
    e.addr = int'(full); e.data = data; e.cyc = cyc;
    if (full < 1024) q10.push_back(e);
    if (full < 16384) q14.push_back(e);
  endtask

  // Interpret the byte just completed, by its position in the record
  task automatic model_byte();
    int k, ll, tt, addr, j, s;
    k = rec.size() - 1;
    ll = rec[0];
    if (k >= 3) begin
      addr = rec[1] * 256 + rec[2];
      tt = rec[3];
      if (k == 3) begin
        if (tt == 0 && ((ll % 2) == 1 || (addr % 2) == 1)) exp_err = 1;
        if (tt == 4 && ll != 2) exp_err = 1;
      end
      if (k == 4 + ll) begin
        s = 0;
        foreach (rec[i]) s += rec[i];
        if ((s % 256) != 0) begin exp_err = 1; phase = 0; end
        else if (tt == 1) begin exp_done = 1; phase = 2; end
        else phase = 0;
      end else if (k >= 4) begin
        j = k - 4;
        if (tt == 0 && (ll % 2) == 0 && (addr % 2) == 0 && (j % 2) == 1)
          push_write(((ext * 65536) + addr + j) / 2, (rec[k] % 64) * 256 + rec[k-1]);
        if (tt == 4 && ll == 2 && j == 1) ext = rec[4] * 256 + rec[5];
      end
    end
  endtask

  task automatic model_char(input int c);
    int v;
    if (phase == 2) begin
    end else if (c == 58) begin
      if (phase == 1) exp_err = 1;
      phase = 1; rec.delete(); half = 0;
    end else if (phase == 1) begin
      v = hexval(c);
      if (v < 0) begin
        exp_err = 1; phase = 0;
      end else if (!half) begin
        hi = v; half = 1;
      end else begin
        half = 0;
        rec.push_back(hi * 16 + v);
        model_byte();
      end
    end
  endtask

  task automatic mon_write(input int w, input int a, input int d);
    wr_t e;
    bit  got;
    got = 0;
    if (w == 0) begin
      if (q10.size() > 0) begin e = q10.pop_front(); got = 1; popped10++; end
    end else begin
      if (q14.size() > 0) begin e = q14.pop_front(); got = 1; popped14++; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL unexpected_write dut%0d: addr %0h data %0h, expected no write", w, a, d);
    end else begin
      chk(w == 0 ? "wr_addr10" : "wr_addr14", a, e.addr);
      chk(w == 0 ? "wr_data10" : "wr_data14", d, e.data);
      chk(w == 0 ? "wr_latency10" : "wr_latency14", cyc, e.cyc + 1);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (we10) mon_write(0, int'(a10), int'(d10));
    if (we14) mon_write(1, int'(a14), int'(d14));
    if (q10.size() > 0 && q10[0].cyc + 1 < cyc) begin
      vectors++; miscompares++;
      $display("FAIL missing_write10: addr %0h data %0h never written", q10[0].addr, q10[0].data);
      q10.delete(0);
    end
    if (q14.size() > 0 && q14[0].cyc + 1 < cyc) begin
      vectors++; miscompares++;
      $display("FAIL missing_write14: addr %0h data %0h never written", q14[0].addr, q14[0].data);
      q14.delete(0);
    end
    chk("busy10", busy10, phase == 1);
    chk("busy14", busy14, phase == 1);
    chk("error10", err10, exp_err);
    chk("error14", err14, exp_err);
    chk("done10", done10, exp_done);
    chk("done14", done14, exp_done);
    chk("wcount10", wc10, popped10);
    chk("wcount14", wc14, popped14);
  end

  function automatic int rgap();
    if ($urandom_range(0, 3) == 0) return $urandom_range(1, 2);
    else return 0;
  endfunction

  task automatic send_char(input int c, input int gap);
    @(negedge clk);
    rx_data = 8'(c); rx_valid = 1'b1;
    model_char(c);
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0; rx_data = 8'h3A;  // a ':' without strobe must be ignored
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0; rx_data = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(int'(s[i]), rgap());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0; rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_addr10", a10, 0);  chk("rst_data10", d10, 0);
    chk("rst_we10", we10, 0);   chk("rst_wc10", wc10, 0);
    chk("rst_addr14", a14, 0);  chk("rst_data14", d14, 0);
    chk("rst_we14", we14, 0);   chk("rst_wc14", wc14, 0);
    rst = 1'b0;
  endtask

  task automatic rand_record();
    int kind, ll, addr, tt, fault, s, p, n;
    int b[$];
    int cq[$];
    int oq[$];
    kind  = $urandom_range(0, 9);
    fault = $urandom_range(0, 24);
    if (kind < 7) begin
      tt = 0; ll = 2 * $urandom_range(0, 8); addr = 2 * $urandom_range(0, 1100);
    end else if (kind == 7) begin
      tt = 4; ll = 2; addr = 0;
    end else begin
      tt = 2 + $urandom_range(0, 3); ll = $urandom_range(0, 5); addr = $urandom_range(0, 65535);
    end
    if (fault == 1 && tt == 0) ll = ll + 1;
    if (fault == 2 && tt == 0) addr = addr + 1;
    if (fault == 3 && tt == 4) ll = 4;
    b.push_back(ll); b.push_back(addr / 256); b.push_back(addr % 256); b.push_back(tt);
    for (int i = 0; i < ll; i++) begin
      if (tt == 4) b.push_back((i == 1 && $urandom_range(0, 3) == 0) ? 1 : 0);
      else b.push_back($urandom_range(0, 255));
    end
    s = 0;
    foreach (b[i]) s += b[i];
    b.push_back((256 - (s % 256)) % 256);
    if (fault == 4) b[b.size() - 1] = b[b.size() - 1] ^ 1;
    foreach (b[i]) begin
      cq.push_back(hexchar(b[i] / 16));
      cq.push_back(hexchar(b[i] % 16));
    end
    p = $urandom_range(0, cq.size() - 1);
    if (fault == 5) begin
      // non-hex character: record abandoned
      for (int i = 0; i < p; i++) oq.push_back(cq[i]);
      oq.push_back(71);
    end else if (fault == 6) begin
      // ':' mid-record, then the full record again
      for (int i = 0; i < p; i++) oq.push_back(cq[i]);
      oq.push_back(58);
      foreach (cq[i]) oq.push_back(cq[i]);
    end else begin
      oq = cq;
    end
    n = $urandom_range(0, 3);
    repeat (n) send_char(($urandom_range(0, 1) == 1) ? 13 : 120, rgap());
    send_char(58, rgap());
    foreach (oq[i]) send_char(oq[i], rgap());
    if ($urandom_range(0, 1) == 1) begin send_char(13, 0); send_char(10, rgap()); end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    do_reset();
    send_str(":020000000828CE\r\n"); idle(3);
    send_str(":02000400ff3fbc"); send_str(":00000001FF");
    send_str(":020000000828CE"); idle(3);
    do_reset();
    send_str(":020000000828CF"); idle(3);
    do_reset();
    send_str(":020000040001F9"); send_str(":02400E00F23F7F"); idle(3);
    do_reset();
    send_str(":02400E00F23F7F"); idle(3);
    do_reset();
    send_str(":0200"); send_str(":"); send_str("00000001FF"); idle(3);
    do_reset();
    send_str(":0200"); do_reset();
    send_str(":020000000828CE"); idle(3);
    do_reset();
    send_str(":0300000008283F8E"); idle(3);
    do_reset();
    for (int r = 0; r < 200; r++) begin
      if ((r % 25) == 24) do_reset();
      rand_record();
    end
    send_str(":00000001FF"); idle(4);
    chk("pending10", q10.size(), 0);
    chk("pending14", q14.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
